// File: rtl/fb_rect_fill_if.sv
`default_nettype none
// -----------------------------------------------------------------------------
// fb_rect_fill_if : rectangle command channel plus frame-buffer write port
// Rev 1.0
// -----------------------------------------------------------------------------
interface fb_rect_fill_if #(
  parameter int ADDR_W = 19,
  parameter int DATA_W = 4
);
  logic              cmd_valid;
  logic              cmd_ready;
  logic [9:0]        cmd_x0;
  logic [8:0]        cmd_y0;
  logic [9:0]        cmd_x1;
  logic [8:0]        cmd_y1;
  logic [DATA_W-1:0] cmd_color;
  logic              hold;
  logic              we;
  logic [ADDR_W-1:0] waddr;
  logic [DATA_W-1:0] wdata;
  logic              busy;
  logic              done;
  logic              err;

  modport master (
    output cmd_valid, cmd_x0, cmd_y0, cmd_x1, cmd_y1, cmd_color, hold,
    input  cmd_ready, we, waddr, wdata, busy, done, err
  );

  modport slave (
    input  cmd_valid, cmd_x0, cmd_y0, cmd_x1, cmd_y1, cmd_color, hold,
    output cmd_ready, we, waddr, wdata, busy, done, err
  );
endinterface
`default_nettype wire

// File: rtl/fb_rect_fill.sv
`default_nettype none
// -----------------------------------------------------------------------------
// fb_rect_fill : fills a rectangle of one palette index, one BRAM write/cycle
// Rev 1.0
// -----------------------------------------------------------------------------
module fb_rect_fill #(
  parameter int H_RES  = 640,
  parameter int V_RES  = 480,
  parameter int ADDR_W = 19,
  parameter int DATA_W = 4
) (
  input wire            clk_100m,
  input wire            reset_n,
  fb_rect_fill_if.slave bus
);
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_FILL = 2'd1,
    S_DONE = 2'd2,
    S_ERR  = 2'd3
  } state_t;

  localparam logic [ADDR_W-1:0] ROW_STEP = ADDR_W'(H_RES);

  state_t            state_q, state_d;
  logic [9:0]        x_q, x_d, x0_q, x0_d, x1_q, x1_d;
  logic [8:0]        y_q, y_d, y1_q, y1_d;
  logic [ADDR_W-1:0] row_q, row_d;
  logic              last_q, last_d;
  logic              cmd_ready_q, cmd_ready_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] waddr_q, waddr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              err_q, err_d;

  logic [9:0]        cur_x, end_x0, end_x1;
  logic [8:0]        cur_y, end_y1;
  logic [ADDR_W-1:0] cur_row, row0;
  logic              at_eol, at_last, cmd_ok, step;

  // H_RES*y0 as y*512 + y*128 (H_RES = 640 layout)
  assign row0   = (ADDR_W'(bus.cmd_y0) << 9) + (ADDR_W'(bus.cmd_y0) << 7);
  assign cmd_ok = (bus.cmd_x0 <= bus.cmd_x1) && (int'(bus.cmd_x1) < H_RES) &&
                  (bus.cmd_y0 <= bus.cmd_y1) && (int'(bus.cmd_y1) < V_RES);

  // Cursor comes from the incoming command on the accept edge, else from the walk.
  always_comb begin
    cur_x   = x_q;
    cur_y   = y_q;
    cur_row = row_q;
    end_x0  = x0_q;
    end_x1  = x1_q;
    end_y1  = y1_q;
    if (state_q == S_IDLE) begin
      cur_x   = bus.cmd_x0;
      cur_y   = bus.cmd_y0;
      cur_row = row0;
      end_x0  = bus.cmd_x0;
      end_x1  = bus.cmd_x1;
      end_y1  = bus.cmd_y1;
    end
    at_eol  = (cur_x == end_x1);
    at_last = at_eol && (cur_y == end_y1);
  end

  always_comb begin
    state_d     = state_q;
    x_d         = x_q;
    y_d         = y_q;
    row_d       = row_q;
    x0_d        = x0_q;
    x1_d        = x1_q;
    y1_d        = y1_q;
    last_d      = last_q;
    cmd_ready_d = cmd_ready_q;
    we_d        = 1'b0;
    waddr_d     = waddr_q;
    wdata_d     = wdata_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    err_d       = 1'b0;
    step        = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (bus.cmd_valid && cmd_ready_q) begin
          cmd_ready_d = 1'b0;
          if (cmd_ok) begin
            state_d = S_FILL;
            x0_d    = bus.cmd_x0;
            x1_d    = bus.cmd_x1;
            y1_d    = bus.cmd_y1;
            wdata_d = bus.cmd_color;
            busy_d  = 1'b1;
            step    = 1'b1;
          end else begin
            state_d = S_ERR;
            err_d   = 1'b1;
          end
        end
      end
      S_FILL: begin
        // last_q means (x1,y1) has already been issued
        if (last_q) begin
          state_d = S_DONE;
          done_d  = 1'b1;
        end else if (!bus.hold) begin
          step = 1'b1;
        end
      end
      S_DONE: begin
        state_d     = S_IDLE;
        cmd_ready_d = 1'b1;
        busy_d      = 1'b0;
      end
      S_ERR: begin
        state_d     = S_IDLE;
        cmd_ready_d = 1'b1;
      end
      default: begin
        state_d     = S_IDLE;
        cmd_ready_d = 1'b1;
        busy_d      = 1'b0;
      end
    endcase

    if (step) begin
      we_d    = 1'b1;
      waddr_d = cur_row + ADDR_W'(cur_x);
      last_d  = at_last;
      x_d     = cur_x + 10'd1;
      y_d     = cur_y;
      row_d   = cur_row;
      if (at_eol) begin
        x_d   = end_x0;
        y_d   = cur_y + 9'd1;
        row_d = cur_row + ROW_STEP;
      end
    end
  end

  always_ff @(posedge clk_100m or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= S_IDLE;
      x_q         <= '0;
      y_q         <= '0;
      row_q       <= '0;
      x0_q        <= '0;
      x1_q        <= '0;
      y1_q        <= '0;
      last_q      <= 1'b0;
      cmd_ready_q <= 1'b1;
      we_q        <= 1'b0;
      waddr_q     <= '0;
      wdata_q     <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      x_q         <= x_d;
      y_q         <= y_d;
      row_q       <= row_d;
      x0_q        <= x0_d;
      x1_q        <= x1_d;
      y1_q        <= y1_d;
      last_q      <= last_d;
      cmd_ready_q <= cmd_ready_d;
      we_q        <= we_d;
      waddr_q     <= waddr_d;
      wdata_q     <= wdata_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      err_q       <= err_d;
    end
  end

  assign bus.cmd_ready = cmd_ready_q;
  assign bus.we        = we_q;
  assign bus.waddr     = waddr_q;
  assign bus.wdata     = wdata_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.err       = err_q;
endmodule
`default_nettype wire
